// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and the default peripheral
// memory map used by the master and the slave wrappers.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] APB_BASE        = 32'h1000_0000;
    localparam int          APB_REGION_BITS = 12;

    // Width of a slave index; a single slave still gets one index bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder_n.sv
// Maps an address onto one of NSLV consecutive 2^REGION_BITS regions above BASE,
// producing a one-hot select and a hit flag.
module apb_addr_decoder_n
    import apb_pkg::*;
#(
    parameter int                NSLV        = 9,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(APB_BASE),
    parameter int                REGION_BITS = APB_REGION_BITS
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [NSLV-1:0]   sel
);
    localparam int IDX_W  = idx_width(NSLV);
    localparam int TOP_LO = REGION_BITS + IDX_W;

    logic [IDX_W-1:0] idx;
    logic             upper_ok;
    logic             unused_offset;

    assign idx           = addr[REGION_BITS +: IDX_W];
    assign upper_ok      = (addr[ADDR_W-1:TOP_LO] == BASE[ADDR_W-1:TOP_LO]);
    assign unused_offset = ^addr[REGION_BITS-1:0];

    // Index values at or above NSLV leave sel empty, so they count as unmapped.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (upper_ok && (idx == IDX_W'(i))) sel[i] = 1'b1;
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/apb_master_nslv.sv
// APB master: latches one CPU request, runs SETUP/ACCESS against the decoded
// slave, handles wait states, PSLVERR, unmapped addresses and hung-slave timeout.
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int                NSLV        = 9,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(APB_BASE),
    parameter int                REGION_BITS = APB_REGION_BITS,
    parameter int                TIMEOUT     = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   req,
    input  logic                   write,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   busy,
    output logic                   ready,
    output logic                   err,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      PADDR,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [DATA_W-1:0]      PWDATA,
    output logic [NSLV-1:0]        PSEL,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);
    localparam int IDX_W = idx_width(NSLV);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int OFS_W = $clog2(NSLV * DATA_W);

    apb_state_e        state, state_nxt;
    logic              hit;
    logic [NSLV-1:0]   sel_dec;
    logic [NSLV-1:0]   sel_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [OFS_W-1:0]  rd_ofs;
    logic              pready_sel;
    logic              pslverr_sel;
    logic [DATA_W-1:0] prdata_sel;
    logic              timeout_hit;

    apb_addr_decoder_n #(
        .NSLV        (NSLV),
        .ADDR_W      (ADDR_W),
        .BASE        (BASE),
        .REGION_BITS (REGION_BITS)
    ) u_dec (
        .addr (addr),
        .hit  (hit),
        .sel  (sel_dec)
    );

    // Response mux keyed by the latched index, so PRDATA never reaches an output combinationally.
    assign rd_ofs      = OFS_W'(idx_q) * OFS_W'(DATA_W);
    assign prdata_sel  = PRDATA[rd_ofs +: DATA_W];
    assign pready_sel  = PREADY[idx_q];
    assign pslverr_sel = PSLVERR[idx_q];

    // wait_cnt counts stalled ACCESS cycles; abort once TIMEOUT of them have passed.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && hit) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready_sel || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sel_q    <= '0;
            idx_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            wait_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        sel_q    <= sel_dec;
                        idx_q    <= addr[REGION_BITS +: IDX_W];
                        paddr_q  <= addr;
                        pwrite_q <= write;
                        pwdata_q <= write ? wdata : '0;
                    end else if (req) begin
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end
                SETUP: wait_cnt <= '0;
                ACCESS: begin
                    if (pready_sel) begin
                        ready <= 1'b1;
                        err   <= pslverr_sel;
                        rdata <= pwrite_q ? '0 : prdata_sel;
                    end else if (timeout_hit) begin
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign PENABLE = (state == ACCESS);
    assign PSEL    = busy ? sel_q    : '0;
    assign PADDR   = busy ? paddr_q  : '0;
    assign PWDATA  = busy ? pwdata_q : '0;
    assign PWRITE  = busy & pwrite_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Scoreboard bench for apb_master_nslv: directed cases plus randomized traffic
// against an address-range / latency reference model.
module tb_apb_master_nslv;
    localparam int          NSLV    = 9;
    localparam int          ADDR_W  = 32;
    localparam int          DATA_W  = 32;
    localparam int          TIMEOUT = 4;
    localparam logic [31:0] BASE    = 32'h1000_0000;

    logic                   PCLK    = 1'b0;
    logic                   PRESET  = 1'b1;
    logic                   req     = 1'b0;
    logic                   write   = 1'b0;
    logic [ADDR_W-1:0]      addr    = '0;
    logic [DATA_W-1:0]      wdata   = '0;
    logic                   busy, ready, err;
    logic [DATA_W-1:0]      rdata;
    logic [ADDR_W-1:0]      PADDR;
    logic                   PWRITE, PENABLE;
    logic [DATA_W-1:0]      PWDATA;
    logic [NSLV-1:0]        PSEL;
    logic [NSLV*DATA_W-1:0] PRDATA  = '0;
    logic [NSLV-1:0]        PREADY  = '0;
    logic [NSLV-1:0]        PSLVERR = '0;

    apb_master_nslv #(
        .NSLV(NSLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BASE(BASE), .REGION_BITS(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .write(write), .addr(addr),
        .wdata(wdata), .busy(busy), .ready(ready), .err(err), .rdata(rdata),
        .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          cyc0;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          free_at = 0;
    // Behaviour of the slave currently being addressed
    int          cur_w = 0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_rd = '0;
    int          acc = 0;
    // Expected bus contents of the transfer in flight
    logic [NSLV-1:0] exp_sel = '0;
    logic [31:0]     exp_addr = '0, exp_wd = '0;
    logic            exp_wr = 1'b0;
    logic            prev_active = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Reference model: a request is taken only if the previous one has completed
    // by the cycle it is presented; mapping is a plain address-range test.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int w, input logic e, input logic [31:0] rd);
        exp_t   x;
        longint off;
        int     slv;
        if (cyc >= free_at) begin
            off = longint'(a) - longint'(BASE);
            if (off >= 0 && off < longint'(NSLV) * 4096) begin
                slv      = int'(off / 4096);
                cur_w    = w;
                cur_err  = e;
                cur_rd   = rd;
                exp_sel  = NSLV'(1) << slv;
                exp_addr = a;
                exp_wr   = wr;
                exp_wd   = wr ? d : 32'h0;
                if (w > TIMEOUT) begin
                    x.lat = TIMEOUT + 3; x.err = 1'b1; x.rdata = '0;
                end else begin
                    x.lat = 3 + w; x.err = e; x.rdata = wr ? 32'h0 : rd;
                end
            end else begin
                x.lat = 1; x.err = 1'b1; x.rdata = '0;
            end
            x.cyc0  = cyc;
            free_at = cyc + x.lat;
            sb.push_back(x);
        end
        req   = 1'b1;
        write = wr;
        addr  = a;
        wdata = d;
        tick();
        req   = 1'b0;
    endtask

    task automatic wait_free();
        while (cyc < free_at) tick();
    endtask

    // Slave responder: selected slave follows the programmed wait/err/data,
    // all other slaves drive noise that must never leak through.
    always @(negedge PCLK) begin
        for (int i = 0; i < NSLV; i++) begin
            if (PSEL[i]) begin
                PRDATA[i*DATA_W +: DATA_W] = cur_rd;
                PSLVERR[i] = cur_err;
                PREADY[i]  = PENABLE && (acc == cur_w);
            end else begin
                PRDATA[i*DATA_W +: DATA_W] = $urandom;
                PSLVERR[i] = 1'($urandom);
                PREADY[i]  = 1'($urandom);
            end
        end
        if (PENABLE) acc++;
        else         acc = 0;
    end

    // Monitor: completions against the scoreboard, bus protocol every cycle.
    always @(negedge PCLK) begin
        exp_t x;
        if (ready === 1'b1) begin
            chk("ready_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("err", 64'(err), 64'(x.err));
                chk("rdata", 64'(rdata), 64'(x.rdata));
                chk("latency", 64'(cyc - x.cyc0), 64'(x.lat));
            end
        end
        chk("busy", 64'(busy), 64'(PSEL != '0));
        if (PSEL != '0) begin
            chk("psel", 64'(PSEL), 64'(exp_sel));
            chk("penable", 64'(PENABLE), 64'(prev_active));
            chk("paddr", 64'(PADDR), 64'(exp_addr));
            chk("pwrite", 64'(PWRITE), 64'(exp_wr));
            chk("pwdata", 64'(PWDATA), 64'(exp_wd));
        end else begin
            chk("idle_bus", 64'(|{PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        end
        prev_active = (PSEL != '0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          kind, w, gap;

        repeat (3) tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_psel", 64'(PSEL), 64'd0);
        PRESET = 1'b0;
        tick();
        free_at = cyc;

        // Zero-wait write, long-wait read, unmapped read, timeout, slave error
        issue(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        wait_free();
        issue(1'b0, 32'h1000_8000, 32'h0, 4, 1'b0, 32'h0000_1234);
        wait_free();
        issue(1'b0, 32'h1000_9000, 32'h0, 0, 1'b0, 32'h0);
        wait_free();
        issue(1'b0, 32'h1000_3010, 32'h0, 9, 1'b0, 32'h5555_AAAA);
        wait_free();
        issue(1'b0, 32'h1000_5008, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
        wait_free();
        tick();

        // Request during SETUP is dropped; request in the ready cycle is taken
        issue(1'b1, 32'h1000_2000, 32'h1111_2222, 0, 1'b0, 32'h0);
        issue(1'b1, 32'h1000_4000, 32'h3333_4444, 0, 1'b0, 32'h0);
        wait_free();
        issue(1'b0, 32'h1000_0FFC, 32'h0, 0, 1'b0, 32'h0BAD_0001);
        wait_free();
        tick();

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE + 32'(NSLV * 4096) + 32'($urandom_range(0, (16 - NSLV) * 4096 - 1));
                    1:       a = BASE - 32'(4 * $urandom_range(1, 64));
                    default: a = $urandom;
                endcase
            end else begin
                a = BASE + 32'($urandom_range(0, NSLV - 1) * 4096) + ($urandom & 32'hFFC);
            end
            w = $urandom_range(0, 6);
            issue(1'($urandom), a, $urandom, w, 1'($urandom_range(0, 3) == 0), $urandom);
            gap = $urandom_range(0, 5);
            repeat (gap) tick();
        end
        wait_free();
        tick();

        // Reset while in ACCESS: bus drops at once, no completion follows
        issue(1'b0, 32'h1000_2040, 32'h0, 9, 1'b0, 32'h7777_7777);
        tick();
        chk("pre_rst_access", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("rst_mid_psel", 64'(PSEL), 64'd0);
        chk("rst_mid_penable", 64'(PENABLE), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_rdata", 64'(rdata), 64'd0);
        if (sb.size() != 0) void'(sb.pop_back());
        free_at = cyc;
        repeat (12) tick();

        for (int t = 0; t < 40 && sb.size() != 0; t++) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
